lane_deskew: RTL
================

Name: lane_deskew

Overview:
- Multi-lane deskew block for the receive path: removes the relative latency between lanes that arrive with different delays.
- Each lane carries a periodic alignment marker.
- The block buffers every lane, measures how far apart the markers arrive, and replays the lanes with per-lane offsets so all markers leave on the same cycle.
- Sits after per-lane decoding and before lane merge/framing.

Parameters:
- LANES, 2, number of lanes (2..8).
- WIDTH, 8, data bits per lane.
- MAX_SKEW, 4, largest tolerated marker spread in valid cycles (1..15); per-lane buffer depth is MAX_SKEW+1.

Ports:
- clk  input  1  posedge active clock
- rst_n  input  1  asynchronous reset, active LOW
- din  input  LANES*WIDTH  lane data, lane i at bits [i*WIDTH +: WIDTH]
- din_marker  input  LANES  bit i high when lane i's current word is an alignment marker
- din_valid  input  1  all lanes carry a valid word this cycle
- dout  output  LANES*WIDTH  deskewed lane data, same packing as din
- dout_marker  output  LANES  marker flags travelling with dout
- dout_valid  output  1  dout holds a deskewed word
- aligned  output  1  high while in ALIGNED state
- deskew_err  output  1  one-cycle pulse on skew overflow or loss of alignment

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). rst_n low clears every buffer, pointer, offset, counter and the FSM.
- Reset values: all outputs 0; FSM in HUNT.
- Only cycles with din_valid=1 advance anything: buffer writes, the skew counter and pointers. din_valid=0 cycles are transparent; the FSM holds state and outputs hold, except that dout_valid is 0.
- Buffers: each lane has a circular buffer of MAX_SKEW+1 entries holding {marker, data}. There is one shared write pointer that wraps from MAX_SKEW to 0.
- HUNT state:
  - Wait for a valid cycle with any din_marker bit set.
  - Latch the set of lanes that have seen their marker, and set skew_cnt=0.
  - If every lane has its marker in the same cycle, go straight to ALIGNED with all offsets 0.
  - Otherwise go to COLLECT.
  - dout_valid=0.
- COLLECT state:
  - Each valid cycle increments skew_cnt.
  - A lane whose marker arrives records nothing new; lanes already seen increment their own offset_i (saturating at MAX_SKEW).
  - When the last lane's marker arrives, with skew_cnt <= MAX_SKEW, go to ALIGNED.
  - If skew_cnt would exceed MAX_SKEW, pulse deskew_err and return to HUNT.
  - A second marker on an already-seen lane also counts as overflow: pulse deskew_err, return to HUNT.
  - dout_valid=0.
- ALIGNED state:
  - Lane i output reads the buffer at wr_ptr - offset_i, mod MAX_SKEW+1.
  - dout, dout_marker and dout_valid are registered, so latency is offset_i+1 valid cycles per lane; the latest lane sees 1 cycle.
  - aligned=1.
- Alignment check in ALIGNED: on any output word where dout_marker is neither all-zero nor all-one:
  - pulse deskew_err;
  - drop aligned, dout_valid=0 from the next cycle;
  - go to HUNT.
  - The offending word itself is still presented with dout_valid=1.
- Simultaneous events: an error and a new marker in the same cycle take the error path; that marker is not used for the new hunt.
- Reset mid-operation: immediate return to the reset state; buffered data is discarded.

Optional Feature:
- Macro LANE_DESKEW_STATS_EN.
- When defined:
  - adds output port realign_cnt, 16 bits;
  - realign_cnt counts entries into ALIGNED, saturating at 0xFFFF;
  - realign_cnt resets to 0.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- LANES=2, MAX_SKEW=4, markers on both lanes in the same valid cycle with data 0xA5/0x5A -> aligned=1 next cycle; dout=0x5AA5 with dout_marker=2'b11 one cycle after the marker.
- Lane 1 marker 3 valid cycles after lane 0, streams 0x00,0x01,.. on each lane -> offset0=3, offset1=0; markers leave together; dout lanes carry equal counter values; deskew_err=0.
- Lane 1 marker 5 cycles late (exceeds MAX_SKEW=4) -> single deskew_err pulse after 5 cycles; FSM in HUNT; aligned=0; no dout_valid.
- While aligned, inject a marker on lane 0 only -> dout_marker=2'b01 presented with dout_valid=1, deskew_err pulse that cycle, aligned=0 next cycle, re-hunt succeeds on the next clean markers.
- Skew of 2 with din_valid toggled 1,0,1,0 -> same alignment as the gapless case; dout_valid=0 on gap cycles.
- rst_n asserted asynchronously mid-ALIGNED -> all outputs 0 immediately; with LANE_DESKEW_STATS_EN, realign_cnt=0 after reset and 1 after the next alignment.

Source files
------------

// File: rtl/lane_deskew.sv
//------------------------------------------------------------------------------
// lane_deskew : buffers each lane, measures marker spread, replays lanes aligned.
// Optional LANE_DESKEW_STATS_EN adds the realign_cnt output. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lane_deskew #(
   parameter int LANES    = 2,
   parameter int WIDTH    = 8,
   parameter int MAX_SKEW = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [LANES*WIDTH-1:0] din,
   input  logic [LANES-1:0]       din_marker,
   input  logic                   din_valid,
   output logic [LANES*WIDTH-1:0] dout,
   output logic [LANES-1:0]       dout_marker,
   output logic                   dout_valid,
   output logic                   aligned,
   output logic                   deskew_err
`ifdef LANE_DESKEW_STATS_EN
   ,
   output logic [15:0]            realign_cnt
`endif
);

   localparam int DEPTH = MAX_SKEW + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_MAX  = PW'(MAX_SKEW);
   localparam logic [PW:0]   DEPTH_V  = (PW+1)'(DEPTH);
   localparam logic [3:0]    SKEW_MAX = 4'(MAX_SKEW);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      ALIGNED = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [3:0]             skew_cnt_q, skew_cnt_d;
   logic [LANES-1:0]       seen_q, seen_d;
   logic [PW-1:0]          offset_q [LANES];
   logic [PW-1:0]          offset_d [LANES];
   logic [WIDTH:0]         mem_q [LANES][DEPTH];
   logic [WIDTH:0]         mem_d [LANES][DEPTH];
   logic [LANES*WIDTH-1:0] dout_q, dout_d;
   logic [LANES-1:0]       dout_marker_q, dout_marker_d;
   logic                   dout_valid_q, dout_valid_d;
   logic                   err_q, err_d;
   logic [PW:0]            rd_idx [LANES];
   logic [LANES*WIDTH-1:0] rd_data;
   logic [LANES-1:0]       rd_marker;
   logic                   collect_ovf;
   logic                   rd_mixed;

   // Spread overflow, or a lane repeating its marker before all lanes arrived.
   assign collect_ovf = (skew_cnt_q >= SKEW_MAX) || (|(din_marker & seen_q));
   assign rd_mixed    = (|rd_marker) && !(&rd_marker);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      mem_d    = mem_q;
      if (din_valid) begin
         wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
         for (int i = 0; i < LANES; i++) begin
            mem_d[i][wr_ptr_q] = {din_marker[i], din[i*WIDTH +: WIDTH]};
         end
      end
   end

   always_comb begin
      offset_d = offset_q;
      if (din_valid) begin
         if (state_q == HUNT && (|din_marker)) begin
            for (int i = 0; i < LANES; i++) offset_d[i] = '0;
         end else if (state_q == COLLECT && !collect_ovf) begin
            for (int i = 0; i < LANES; i++) begin
               if (seen_q[i] && offset_q[i] != PTR_MAX) offset_d[i] = offset_q[i] + 1'b1;
            end
         end
      end
   end

   // Offset 0 bypasses the buffer so the latest lane sees only the output register.
   always_comb begin
      rd_data   = '0;
      rd_marker = '0;
      for (int i = 0; i < LANES; i++) begin
         rd_idx[i] = {1'b0, wr_ptr_q} + DEPTH_V - {1'b0, offset_d[i]};
         if (rd_idx[i] >= DEPTH_V) rd_idx[i] = rd_idx[i] - DEPTH_V;
         if (offset_d[i] == '0) begin
            rd_data[i*WIDTH +: WIDTH] = din[i*WIDTH +: WIDTH];
            rd_marker[i]              = din_marker[i];
         end else begin
            rd_data[i*WIDTH +: WIDTH] = mem_q[i][rd_idx[i][PW-1:0]][WIDTH-1:0];
            rd_marker[i]              = mem_q[i][rd_idx[i][PW-1:0]][WIDTH];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      skew_cnt_d    = skew_cnt_q;
      seen_d        = seen_q;
      err_d         = 1'b0;
      dout_d        = dout_q;
      dout_marker_d = dout_marker_q;
      dout_valid_d  = 1'b0;
      if (din_valid) begin
         case (state_q)
            HUNT: begin
               if (|din_marker) begin
                  seen_d     = din_marker;
                  skew_cnt_d = '0;
                  state_d    = (&din_marker) ? ALIGNED : COLLECT;
               end
            end
            COLLECT: begin
               if (collect_ovf) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  skew_cnt_d = skew_cnt_q + 1'b1;
                  seen_d     = seen_q | din_marker;
                  if (&seen_d) state_d = ALIGNED;
               end
            end
            ALIGNED: begin
               if (rd_mixed) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
         // The offending word of a failed check is still presented as valid.
         if (state_q == ALIGNED || state_d == ALIGNED) begin
            dout_d        = rd_data;
            dout_marker_d = rd_marker;
            dout_valid_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         wr_ptr_q      <= '0;
         skew_cnt_q    <= '0;
         seen_q        <= '0;
         dout_q        <= '0;
         dout_marker_q <= '0;
         dout_valid_q  <= 1'b0;
         err_q         <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            offset_q[i] <= '0;
            for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
         end
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         skew_cnt_q    <= skew_cnt_d;
         seen_q        <= seen_d;
         dout_q        <= dout_d;
         dout_marker_q <= dout_marker_d;
         dout_valid_q  <= dout_valid_d;
         err_q         <= err_d;
         offset_q      <= offset_d;
         mem_q         <= mem_d;
      end
   end

   assign dout        = dout_q;
   assign dout_marker = dout_marker_q;
   assign dout_valid  = dout_valid_q;
   assign aligned     = (state_q == ALIGNED);
   assign deskew_err  = err_q;

`ifdef LANE_DESKEW_STATS_EN
   logic [15:0] realign_cnt_q, realign_cnt_d;

   always_comb begin
      realign_cnt_d = realign_cnt_q;
      if (state_q != ALIGNED && state_d == ALIGNED && realign_cnt_q != 16'hFFFF)
         realign_cnt_d = realign_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) realign_cnt_q <= '0;
      else        realign_cnt_q <= realign_cnt_d;
   end

   assign realign_cnt = realign_cnt_q;
`endif

endmodule

`default_nettype wire
